// File: rtl/pe_accum_blockfp_multi.sv
// Multi-channel block-floating-point accumulator: align, saturating per-channel
// accumulate, then normalise a flushed channel into a small float.
module pe_accum_blockfp_multi #(
  parameter int CHANNELS              = 4,
  parameter int DOT_OUTPUT_WIDTH      = 16,
  parameter int EXPONENT_WIDTH        = 4,
  parameter int GUARD_WIDTH           = 8,
  parameter int LSB_SCALE             = 16,
  parameter int RESULT_EXPONENT_WIDTH = 8,
  parameter int RESULT_MANTISSA_WIDTH = 7,
  parameter int RESULT_EXPONENT_BIAS  = 127,
  localparam int CH_W         = $clog2(CHANNELS),
  localparam int ACCUM_WIDTH  = DOT_OUTPUT_WIDTH + 2 * ((1 << EXPONENT_WIDTH) - 1) + GUARD_WIDTH,
  localparam int RESULT_WIDTH = 1 + RESULT_EXPONENT_WIDTH + RESULT_MANTISSA_WIDTH
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        i_valid,
  input  logic [CH_W-1:0]             i_channel,
  input  logic [EXPONENT_WIDTH-1:0]   i_feature_exp,
  input  logic [EXPONENT_WIDTH-1:0]   i_filter_exp,
  input  logic [DOT_OUTPUT_WIDTH-1:0] i_dot_output,
  input  logic                        i_flush_accumulator,
  output logic                        o_valid,
  output logic [CH_W-1:0]             o_channel,
  output logic [RESULT_WIDTH-1:0]     o_result,
  output logic                        o_overflow
);

  localparam int AW  = ACCUM_WIDTH;
  localparam int DW  = DOT_OUTPUT_WIDTH;
  localparam int MW  = AW - 1;
  localparam int PW  = $clog2(AW);
  localparam int REW = RESULT_EXPONENT_WIDTH;
  localparam int RMW = RESULT_MANTISSA_WIDTH;

  localparam logic signed [AW:0] POS_LIM = {2'b00, {(AW-1){1'b1}}};
  localparam logic signed [AW:0] NEG_LIM = -POS_LIM;
  localparam logic signed [31:0] E_OFFSET = 32'(RESULT_EXPONENT_BIAS - LSB_SCALE);
  localparam logic signed [31:0] E_MAX    = 32'((1 << RESULT_EXPONENT_WIDTH) - 1);

  // ---------------- S1: align ----------------
  logic                     ch_ok;
  logic [EXPONENT_WIDTH:0]  esum;
  logic [AW-1:0]            aligned_in;

  assign ch_ok      = (int'(i_channel) < CHANNELS);
  assign esum       = {1'b0, i_feature_exp} + {1'b0, i_filter_exp};
  assign aligned_in = {{(AW-DW){i_dot_output[DW-1]}}, i_dot_output} << esum;

  logic            s1_valid;
  logic            s1_flush;
  logic [CH_W-1:0] s1_ch;
  logic [AW-1:0]   s1_aligned;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_valid   <= 1'b0;
      s1_flush   <= 1'b0;
      s1_ch      <= '0;
      s1_aligned <= '0;
    end else begin
      s1_valid   <= i_valid & ch_ok;
      s1_flush   <= i_flush_accumulator & ch_ok;
      s1_ch      <= i_channel;
      s1_aligned <= i_valid ? aligned_in : '0;
    end
  end

  // ---------------- S2: saturating read-modify-write ----------------
  logic [AW-1:0]        accum [CHANNELS];
  logic [CHANNELS-1:0]  sat;
  logic [AW-1:0]        acc_rd;
  logic signed [AW:0]   sum_ext;
  logic [AW-1:0]        clamped;
  logic                 sat_hit;

  assign acc_rd  = accum[s1_ch];
  assign sum_ext = $signed({acc_rd[AW-1], acc_rd}) + $signed({s1_aligned[AW-1], s1_aligned});

  always_comb begin
    clamped = sum_ext[AW-1:0];
    sat_hit = 1'b0;
    if (sum_ext > POS_LIM) begin
      clamped = POS_LIM[AW-1:0];
      sat_hit = 1'b1;
    end else if (sum_ext < NEG_LIM) begin
      clamped = NEG_LIM[AW-1:0];
      sat_hit = 1'b1;
    end
  end

  logic            s2_valid;
  logic [CH_W-1:0] s2_ch;
  logic [AW-1:0]   s2_sum;
  logic            s2_sat;

  // A flush captures the updated sum and clears the channel in the same edge,
  // so a sample on the next cycle naturally starts from zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) accum[c] <= '0;
      sat      <= '0;
      s2_valid <= 1'b0;
      s2_ch    <= '0;
      s2_sum   <= '0;
      s2_sat   <= 1'b0;
    end else begin
      s2_valid <= s1_flush;
      if (s1_flush) begin
        s2_ch        <= s1_ch;
        s2_sum       <= clamped;
        s2_sat       <= sat[s1_ch] | sat_hit;
        accum[s1_ch] <= '0;
        sat[s1_ch]   <= 1'b0;
      end else if (s1_valid) begin
        accum[s1_ch] <= clamped;
        if (sat_hit) sat[s1_ch] <= 1'b1;
      end
    end
  end

  // ---------------- S3: normalise ----------------
  logic                    sign;
  logic [AW-1:0]           neg_sum;
  logic [MW-1:0]           mag;
  logic [PW-1:0]           p;
  logic [PW-1:0]           shamt;
  logic [MW-1:0]           norm;
  logic [RMW-1:0]          mantissa;
  logic signed [31:0]      e_biased;
  logic [RESULT_WIDTH-1:0] result_next;

  assign sign    = s2_sum[AW-1];
  assign neg_sum = -s2_sum;
  // Symmetric clamping guarantees |sum| fits in AW-1 bits.
  assign mag     = sign ? neg_sum[MW-1:0] : s2_sum[MW-1:0];

  always_comb begin
    p = '0;
    for (int i = 0; i < MW; i++) begin
      if (mag[i]) p = PW'(i);
    end
  end

  assign shamt    = PW'(MW - 1) - p;
  assign norm     = mag << shamt;
  assign mantissa = norm[MW-2 -: RMW];
  assign e_biased = $signed(32'(p)) + E_OFFSET;

  always_comb begin
    result_next = '0;
    if ((mag != '0) && (e_biased > 0)) begin
      if (e_biased >= E_MAX)
        result_next = {sign, {(REW-1){1'b1}}, 1'b0, {RMW{1'b1}}};
      else
        result_next = {sign, e_biased[REW-1:0], mantissa};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      o_valid    <= 1'b0;
      o_channel  <= '0;
      o_result   <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= s2_valid;
      if (s2_valid) begin
        o_channel  <= s2_ch;
        o_result   <= result_next;
        o_overflow <= s2_sat;
      end
    end
  end

endmodule

// File: tb/tb_pe_accum_blockfp_multi.sv
// Self-checking bench for pe_accum_blockfp_multi: directed plan cases plus a
// randomized run against an arithmetic reference model.
module tb_pe_accum_blockfp_multi;

  localparam int CHANNELS = 4;
  localparam int CH_W     = 2;
  localparam longint LIM  = (64'sd1 <<< 53) - 1;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            i_valid = 1'b0;
  logic [CH_W-1:0] i_channel = '0;
  logic [3:0]      i_feature_exp = '0;
  logic [3:0]      i_filter_exp = '0;
  logic [15:0]     i_dot_output = '0;
  logic            i_flush_accumulator = 1'b0;
  logic            o_valid;
  logic [CH_W-1:0] o_channel;
  logic [15:0]     o_result;
  logic            o_overflow;

  int total = 0;
  int bad   = 0;

  longint model_acc [CHANNELS];
  bit     model_sat [CHANNELS];

  typedef struct {
    bit          fl;
    int          ch;
    logic [15:0] res;
    bit          ovf;
  } rec_t;

  pe_accum_blockfp_multi dut (
    .clock               (clock),
    .resetn              (resetn),
    .i_valid             (i_valid),
    .i_channel           (i_channel),
    .i_feature_exp       (i_feature_exp),
    .i_filter_exp        (i_filter_exp),
    .i_dot_output        (i_dot_output),
    .i_flush_accumulator (i_flush_accumulator),
    .o_valid             (o_valid),
    .o_channel           (o_channel),
    .o_result            (o_result),
    .o_overflow          (o_overflow)
  );

  always #5 clock = ~clock;

  // Float value of an exact integer sum whose LSB weighs 2^-16.
  function automatic logic [15:0] to_float(input longint s);
    longint mag;
    longint m;
    int     p;
    int     e;
    if (s == 0) return 16'h0000;
    mag = (s < 0) ? -s : s;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = p + 127 - 16;
    m = ((mag << 7) >> p) & 127;
    if (e <= 0) return 16'h0000;
    if (e >= 255) return {(s < 0), 8'hFE, 7'h7F};
    return {(s < 0), 8'(e), 7'(m)};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CHANNELS; c++) begin
      model_acc[c] = 0;
      model_sat[c] = 0;
    end
  endtask

  // Presents one cycle of input and returns what the model expects 3 cycles on.
  task automatic drive(input bit v, input int ch, input int fe, input int we,
                       input int dot, input bit fl, output rec_t r);
    i_valid             = v;
    i_channel           = CH_W'(ch);
    i_feature_exp       = 4'(fe);
    i_filter_exp        = 4'(we);
    i_dot_output        = 16'(dot);
    i_flush_accumulator = fl;
    if (v) begin
      model_acc[ch] += longint'(dot) * (64'sd1 <<< (fe + we));
      if (model_acc[ch] > LIM) begin
        model_acc[ch] = LIM;
        model_sat[ch] = 1;
      end else if (model_acc[ch] < -LIM) begin
        model_acc[ch] = -LIM;
        model_sat[ch] = 1;
      end
    end
    r.fl = fl; r.ch = ch; r.res = 16'h0000; r.ovf = 0;
    if (fl) begin
      r.res = to_float(model_acc[ch]);
      r.ovf = model_sat[ch];
      model_acc[ch] = 0;
      model_sat[ch] = 0;
    end
    @(negedge clock);
  endtask

  task automatic wait_out(output bit got);
    i_valid = 0;
    i_flush_accumulator = 0;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (o_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    model_clear();
    resetn = 0;
    @(negedge clock);
    @(negedge clock);
    total++; if (o_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset.valid got %b want 0", o_valid); end
    total++; if (o_channel !== '0)   begin bad++; $display("[TB] FAIL reset.channel got %0d want 0", o_channel); end
    total++; if (o_result !== 16'h0) begin bad++; $display("[TB] FAIL reset.result got %h want 0000", o_result); end
    total++; if (o_overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset.overflow got %b want 0", o_overflow); end
    resetn = 1;
    @(negedge clock);
  endtask

  task automatic test_single();
    rec_t r;
    bit got;
    drive(1, 0, 0, 0, 3, 1, r);
    i_valid = 0; i_flush_accumulator = 0;
    @(negedge clock);
    total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL single.early got %b want 0", o_valid); end
    @(negedge clock);
    got = (o_valid === 1'b1);
    total++; if (!got) begin bad++; $display("[TB] FAIL single.latency got %b want 1", o_valid); end
    total++; if (o_channel !== 2'd0)    begin bad++; $display("[TB] FAIL single.channel got %0d want 0", o_channel); end
    total++; if (o_result !== 16'h3840) begin bad++; $display("[TB] FAIL single.result got %h want 3840", o_result); end
    total++; if (o_overflow !== 1'b0)   begin bad++; $display("[TB] FAIL single.overflow got %b want 0", o_overflow); end
    @(negedge clock);
    total++; if (o_valid !== 1'b0) begin bad++; $display("[TB] FAIL single.pulse got %b want 0", o_valid); end
    total++; if (o_result !== 16'h3840) begin bad++; $display("[TB] FAIL single.hold got %h want 3840", o_result); end
  endtask

  task automatic test_signed();
    rec_t r;
    bit got;
    drive(1, 1, 1, 1, -5, 0, r);
    drive(1, 1, 0, 0, 4, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL signed.timeout got 0 want 1"); end
    total++; if (o_channel !== 2'd1)    begin bad++; $display("[TB] FAIL signed.channel got %0d want 1", o_channel); end
    total++; if (o_result !== 16'hB980) begin bad++; $display("[TB] FAIL signed.result got %h want b980", o_result); end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    bit got;
    drive(1, 0, 0, 0, 1, 0, r);
    drive(1, 1, 0, 0, 2, 0, r);
    drive(1, 0, 0, 0, 1, 0, r);
    drive(1, 0, 0, 0, 1, 0, r);
    drive(0, 0, 0, 0, 0, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL b2b.ch0.timeout got 0 want 1"); end
    total++; if (o_channel !== 2'd0)    begin bad++; $display("[TB] FAIL b2b.ch0.channel got %0d want 0", o_channel); end
    total++; if (o_result !== 16'h3840) begin bad++; $display("[TB] FAIL b2b.ch0.result got %h want 3840", o_result); end
    drive(0, 1, 0, 0, 0, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL b2b.ch1.timeout got 0 want 1"); end
    total++; if (o_channel !== 2'd1)    begin bad++; $display("[TB] FAIL b2b.ch1.channel got %0d want 1", o_channel); end
    total++; if (o_result !== 16'h3800) begin bad++; $display("[TB] FAIL b2b.ch1.result got %h want 3800", o_result); end
  endtask

  task automatic test_saturation();
    rec_t r;
    bit got;
    for (int n = 0; n < 260; n++) drive(1, 2, 15, 15, 32'h7FFF, 0, r);
    drive(0, 2, 0, 0, 0, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL sat.timeout got 0 want 1"); end
    total++; if (o_channel !== 2'd2)    begin bad++; $display("[TB] FAIL sat.channel got %0d want 2", o_channel); end
    total++; if (o_result !== 16'h51FF) begin bad++; $display("[TB] FAIL sat.result got %h want 51ff", o_result); end
    total++; if (o_overflow !== 1'b1)   begin bad++; $display("[TB] FAIL sat.overflow got %b want 1", o_overflow); end
    drive(0, 2, 0, 0, 0, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL sat.clear.timeout got 0 want 1"); end
    total++; if (o_result !== 16'h0000) begin bad++; $display("[TB] FAIL sat.clear.result got %h want 0000", o_result); end
    total++; if (o_overflow !== 1'b0)   begin bad++; $display("[TB] FAIL sat.clear.overflow got %b want 0", o_overflow); end
  endtask

  task automatic test_idle_flush();
    rec_t r;
    bit got;
    drive(0, 3, 0, 0, 0, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL idle.timeout got 0 want 1"); end
    total++; if (o_channel !== 2'd3)    begin bad++; $display("[TB] FAIL idle.channel got %0d want 3", o_channel); end
    total++; if (o_result !== 16'h0000) begin bad++; $display("[TB] FAIL idle.result got %h want 0000", o_result); end
    drive(1, 3, 0, 0, 3, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL simul.timeout got 0 want 1"); end
    total++; if (o_result !== 16'h3840) begin bad++; $display("[TB] FAIL simul.result got %h want 3840", o_result); end
  endtask

  task automatic test_random();
    rec_t q[$];
    rec_t r;
    rec_t e;
    for (int n = 0; n < 402; n++) begin
      if (n < 400)
        drive($urandom_range(0, 3) != 0, $urandom_range(0, CHANNELS - 1),
              $urandom_range(0, 15), $urandom_range(0, 15),
              int'($signed(16'($urandom))), $urandom_range(0, 4) == 0, r);
      else
        drive(0, 0, 0, 0, 0, 0, r);
      q.push_back(r);
      if (q.size() == 3) begin
        e = q.pop_front();
        total++;
        if (o_valid !== e.fl) begin
          bad++; $display("[TB] FAIL rand.valid step %0d got %b want %b", n, o_valid, e.fl);
        end else if (e.fl) begin
          total++;
          if (o_channel !== CH_W'(e.ch) || o_result !== e.res || o_overflow !== e.ovf) begin
            bad++;
            $display("[TB] FAIL rand.output step %0d got ch=%0d res=%h ovf=%b want ch=%0d res=%h ovf=%b",
                     n, o_channel, o_result, o_overflow, e.ch, e.res, e.ovf);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    rec_t r;
    bit got;
    bit seen;
    drive(1, 0, 0, 0, 3, 1, r);
    wait_out(got);
    drive(1, 0, 2, 3, 77, 0, r);
    drive(0, 0, 0, 0, 0, 1, r);
    i_valid = 0; i_flush_accumulator = 0;
    resetn = 0;
    #1;
    total++; if (o_result !== 16'h0000) begin bad++; $display("[TB] FAIL rstmid.result got %h want 0000", o_result); end
    total++; if (o_valid !== 1'b0)      begin bad++; $display("[TB] FAIL rstmid.valid got %b want 0", o_valid); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (o_valid !== 1'b0) seen = 1;
    end
    total++; if (seen) begin bad++; $display("[TB] FAIL rstmid.pulse got 1 want 0"); end
    model_clear();
    resetn = 1;
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 1, r);
    wait_out(got);
    total++; if (!got) begin bad++; $display("[TB] FAIL rstmid.timeout got 0 want 1"); end
    total++; if (o_result !== r.res)    begin bad++; $display("[TB] FAIL rstmid.model got %h want %h", o_result, r.res); end
    total++; if (o_result !== 16'h0000) begin bad++; $display("[TB] FAIL rstmid.after got %h want 0000", o_result); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_saturation();
    test_idle_flush();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_accum_blockfp_multi.md
Name: pe_accum_blockfp_multi

Overview:
- Multi-channel, time-interleaved block-floating-point accumulator built entirely from ALM logic, with no vendor DSP primitives.
- Successor to the single-channel DSP accumulator at the PE output.
- Each input is a dot-product integer plus a feature exponent and a filter exponent. The block aligns each input into a wide per-channel fixed-point accumulator and saturates on overflow.
- On flush, it normalises the channel's sum to the result float format and emits it tagged with the channel index.

Parameters:
- CHANNELS, 4, number of independent accumulators; must be >= 2.
- DOT_OUTPUT_WIDTH, 16, two's-complement width of i_dot_output.
- EXPONENT_WIDTH, 4, width of each input exponent; both exponents are unsigned.
- GUARD_WIDTH, 8, extra headroom bits in the accumulator.
- LSB_SCALE, 16, the accumulator LSB weighs 2^-LSB_SCALE.
- RESULT_EXPONENT_WIDTH, 8, result exponent width.
- RESULT_MANTISSA_WIDTH, 7, result stored-mantissa width.
- RESULT_EXPONENT_BIAS, 127, result exponent bias.
- Derived: CH_W = $clog2(CHANNELS); ACCUM_WIDTH = DOT_OUTPUT_WIDTH + 2*(2^EXPONENT_WIDTH-1) + GUARD_WIDTH (54 at defaults).
- Derived: RESULT_WIDTH = 1 + RESULT_EXPONENT_WIDTH + RESULT_MANTISSA_WIDTH.

Ports:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample valid.
- i_channel  in  CH_W  target accumulator.
- i_feature_exp  in  EXPONENT_WIDTH  feature block exponent.
- i_filter_exp  in  EXPONENT_WIDTH  filter block exponent.
- i_dot_output  in  DOT_OUTPUT_WIDTH  signed dot product.
- i_flush_accumulator  in  1  emit and clear i_channel; applies with or without i_valid.
- o_valid  out  1  result valid, single-cycle pulse.
- o_channel  out  CH_W  channel of o_result.
- o_result  out  RESULT_WIDTH  {sign, exponent, mantissa}.
- o_overflow  out  1  the emitted channel saturated during this accumulation.

Behaviour:
- Reset (async, resetn=0):
  - All accumulators, sticky-saturation flags and pipeline valids are cleared to 0.
  - o_valid=0, o_channel=0, o_result=0, o_overflow=0.
  - Samples in flight are discarded. Operation resumes on the first edge after deassertion.
- No backpressure: one sample and/or one flush is accepted every cycle. i_channel values >= CHANNELS are ignored (no update, no output).
- S1, registered at edge 1:
  - esum = i_feature_exp + i_filter_exp, width EXPONENT_WIDTH+1.
  - aligned = sign_extend(i_dot_output, ACCUM_WIDTH) << esum.
  - Channel, valid and flush are registered alongside.
  - When i_valid=0, aligned is forced to 0.
- S2, accumulate at edge 2:
  - Single-cycle read-modify-write of accum[ch]: sum = accum[ch] + aligned, computed in ACCUM_WIDTH+1 bits.
  - If sum > 2^(ACCUM_WIDTH-1)-1, clamp to +(2^(ACCUM_WIDTH-1)-1) and set sat[ch].
  - If sum < -(2^(ACCUM_WIDTH-1)-1), clamp to the symmetric negative limit and set sat[ch].
  - If flush: sum and sat[ch] are latched into the S2 output register, then accum[ch] and sat[ch] are cleared at the same edge.
  - Back-to-back samples to the same channel need no forwarding.
  - A sample arriving the cycle after a flush of its channel starts from 0.
- S3, normalise, registered at edge 3:
  - sign = sum MSB; mag = |sum|.
  - p = leading-one position of mag.
  - Biased exponent E = p + RESULT_EXPONENT_BIAS - LSB_SCALE, computed signed and wide.
  - Mantissa = the RESULT_MANTISSA_WIDTH bits immediately below the leading one, truncated; zero-padded when p < RESULT_MANTISSA_WIDTH.
  - mag=0 or E<=0: result = {sign=0, 0, 0}.
  - E >= 2^RESULT_EXPONENT_WIDTH-1: result = max finite, i.e. exponent {1..1,0}, mantissa all ones, sign kept.
- Latency: a flush presented at cycle 0 gives o_valid=1 at cycle 3, carrying o_channel, o_result and o_overflow.
- o_result, o_channel and o_overflow hold their values when o_valid=0.

Test Plan:
- Default params. ch0: dot=3, exps 0/0, with flush -> cycle 3: o_valid=1, o_channel=0, o_result=0x3840, o_overflow=0.
- ch1: dot=-5, exps 1/1; next cycle dot=4, exps 0/0 with flush -> o_result=0xB980, o_channel=1.
- Interleaving on ch0/ch1/ch0/ch0:
  - Stimulus: dot=1,2,1,1, all exps 0, then flush ch0 -> 0x3840 (sum 3).
  - Then flush ch1 -> 0x3800 (sum 2).
  - The back-to-back same-channel updates must not be lost.
- Saturation: ch2 receives 260 samples of dot=0x7FFF, exps 15/15, then flush -> o_result=0x51FF, o_overflow=1.
  - A following flush of ch2 -> o_result=0x0000, o_overflow=0.
- Flush with i_valid=0 on an idle channel 3 -> o_valid=1, o_channel=3, o_result=0x0000.
  - A simultaneous valid sample in the same cycle as its flush is included in the emitted sum.
- Reset mid-operation:
  - Stimulus: accumulate into ch0 and issue a flush; assert resetn=0 one cycle later.
  - Required: no o_valid pulse; all outputs go to 0 immediately.
  - After release, flush ch0 -> o_result=0x0000.
